rle_image_decompressor: RTL and testbench
=========================================

Name: rle_image_decompressor

Overview:
- Upstream producer of the decompressed-image address stream. Its RAM address output drives the AddressInDecompressed leg of the RAM address mux, selected when the mux select is Load=1, Image=0, Layer=0.
- Accepts run-length-encoded words from the file reader over a valid/ready handshake.
- Expands each word into consecutive RAM pixel writes starting at a base address.
- Asserts Load while active and pulses Done when the image is complete.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- PIXEL_WIDTH, 8, pixel value width (low field of an input word).
- RUN_WIDTH, 8, run-length field width (high field of an input word).
- IMAGE_SIZE, 784, pixels per image (28x28); must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to decompress one image; ignored unless idle.
- BaseAddress  in  ADDR_WIDTH  RAM address of pixel 0; sampled on accepted Start.
- InData  in  RUN_WIDTH+PIXEL_WIDTH  compressed word {run[RUN_WIDTH-1:0], pixel[PIXEL_WIDTH-1:0]}.
- InValid  in  1  InData valid.
- InReady  out  1  block accepts InData this cycle.
- AddressInDecompressed  out  ADDR_WIDTH  RAM write address, to the address mux.
- DataToRAM  out  PIXEL_WIDTH  pixel write data.
- WriteEnable  out  1  RAM write strobe.
- Load  out  1  high while busy; drives the mux Load select.
- Done  out  1  one-cycle completion pulse.
- Overflow  out  1  sticky flag: input encoded more than IMAGE_SIZE pixels.
- PixelCount  out  ADDR_WIDTH  pixels written in the current or last image.

Behaviour:
- Reset (async, rst=1), required values:
  - Outputs: InReady=0, AddressInDecompressed=0, DataToRAM=0, WriteEnable=0, Load=0, Done=0, Overflow=0, PixelCount=0.
  - State: IDLE; internal run counter, pixel register and base register all 0.
- Reset mid-operation aborts immediately. No Done pulse; partial RAM contents are left as written.
- States: IDLE, FETCH, EXPAND, FINISH.
- IDLE:
  - Load=0, InReady=0.
  - Start=1 latches BaseAddress, clears PixelCount and Overflow, and moves to FETCH next cycle.
- FETCH:
  - Load=1, InReady=1, WriteEnable=0.
  - A transfer occurs on a clock edge where InValid=1 and InReady=1.
  - run==0 is the end-of-image marker: go to FINISH with no write. This is an early end, so PixelCount may be below IMAGE_SIZE.
  - run>0: latch run and pixel, go to EXPAND.
- EXPAND:
  - Load=1, InReady=0, WriteEnable=1.
  - DataToRAM = latched pixel.
  - AddressInDecompressed = BaseAddress + PixelCount, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - Each cycle: PixelCount+1, run-1.
  - If PixelCount+1 == IMAGE_SIZE on this write, go to FINISH. If run>1 at that point, also set Overflow=1; the remaining run is discarded.
  - Otherwise, if run==1, go to FETCH.
  - Otherwise stay in EXPAND.
- FINISH:
  - Done=1 for exactly one cycle, Load=1 during it, WriteEnable=0.
  - Next state IDLE.
- Latency:
  - Accepted Start at edge k: InReady=1 in cycle k+1.
  - Word accepted at edge m: writes occupy cycles m+1 through m+run, one pixel per cycle, no bubbles within a run.
  - Between runs there is one FETCH cycle minimum; the next word cannot be accepted in the same cycle as the final write.
- WriteEnable, AddressInDecompressed and DataToRAM are decoded from registered state only, with no combinational path from inputs.
- InReady depends only on state.
- When WriteEnable=0, AddressInDecompressed holds BaseAddress+PixelCount and DataToRAM holds its last value.
- Start while not IDLE is ignored, including in the FINISH cycle.
- Start and InValid asserted together in IDLE: only Start is acted on; the word is not consumed.
- Overflow and PixelCount hold after FINISH until the next accepted Start.

Test Plan:
- Reset then idle: rst pulse, Start=0 -> all outputs 0, InReady=0, Load=0, no writes.
- Basic expansion: IMAGE_SIZE=8, Base=0x0100, words {3,0xAA},{5,0x55} always valid -> writes 0xAA @0x0100–0x0102, FETCH gap, 0x55 @0x0103–0x0107, Done pulse one cycle after last write, PixelCount=8, Overflow=0.
- End marker: IMAGE_SIZE=8, words {2,0x11},{0,x} -> two writes @Base, Base+1; Done; PixelCount=2; no third write.
- Overflow: IMAGE_SIZE=8, word {10,0x7F} -> exactly 8 writes, Overflow=1, Done pulse, next word not consumed; next Start clears Overflow.
- Handshake stalls: InValid toggling 0/1 every cycle, and Start held during EXPAND -> no write while in FETCH with InValid=0, identical RAM contents to the stall-free run, Start ignored.
- Wrap and abort: Base=0xFFFE, word {4,0x33} -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. Repeat with rst asserted mid-run -> immediate IDLE, no Done, Load=0.

Source files
------------

// File: rtl/rle_image_decompressor.sv
// Run-length image decompressor: expands {run, pixel} words from the file reader
// into consecutive RAM writes starting at a latched base address.
module rle_image_decompressor #(
    parameter int ADDR_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 8,
    parameter int RUN_WIDTH   = 8,
    parameter int IMAGE_SIZE  = 784
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Start,
    input  logic [ADDR_WIDTH-1:0]            BaseAddress,
    input  logic [RUN_WIDTH+PIXEL_WIDTH-1:0] InData,
    input  logic                             InValid,
    output logic                             InReady,
    output logic [ADDR_WIDTH-1:0]            AddressInDecompressed,
    output logic [PIXEL_WIDTH-1:0]           DataToRAM,
    output logic                             WriteEnable,
    output logic                             Load,
    output logic                             Done,
    output logic                             Overflow,
    output logic [ADDR_WIDTH-1:0]            PixelCount
);

    typedef enum logic [1:0] {IDLE, FETCH, EXPAND, FINISH} state_t;

    localparam logic [ADDR_WIDTH-1:0] IMAGE_LAST = ADDR_WIDTH'(IMAGE_SIZE);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [RUN_WIDTH-1:0]    run_q, run_d;
    logic [PIXEL_WIDTH-1:0]  pixel_q, pixel_d;
    logic                    overflow_q, overflow_d;
    logic                    ready_q, load_q, we_q, done_q;

    logic [RUN_WIDTH-1:0]    inRun;
    logic [PIXEL_WIDTH-1:0]  inPixel;
    logic [ADDR_WIDTH-1:0]   countInc;

    assign inRun    = InData[RUN_WIDTH+PIXEL_WIDTH-1:PIXEL_WIDTH];
    assign inPixel  = InData[PIXEL_WIDTH-1:0];
    assign countInc = count_q + ADDR_WIDTH'(1);

    // Next-state logic; a run that reaches the image end is cut short and flagged.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        run_d      = run_q;
        pixel_d    = pixel_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    base_d     = BaseAddress;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (InValid) begin
                    if (inRun == '0) begin
                        state_d = FINISH;
                    end else begin
                        run_d   = inRun;
                        pixel_d = inPixel;
                        state_d = EXPAND;
                    end
                end
            end
            EXPAND: begin
                count_d = countInc;
                run_d   = run_q - RUN_WIDTH'(1);
                if (countInc == IMAGE_LAST) begin
                    state_d = FINISH;
                    if (run_q > RUN_WIDTH'(1)) begin
                        overflow_d = 1'b1;
                    end
                end else if (run_q == RUN_WIDTH'(1)) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered output strobes, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            run_q      <= '0;
            pixel_q    <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            load_q     <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            run_q      <= run_d;
            pixel_q    <= pixel_d;
            overflow_q <= overflow_d;
            ready_q    <= (state_d == FETCH);
            load_q     <= (state_d != IDLE);
            we_q       <= (state_d == EXPAND);
            done_q     <= (state_d == FINISH);
        end
    end

    assign InReady               = ready_q;
    assign Load                  = load_q;
    assign WriteEnable           = we_q;
    assign Done                  = done_q;
    assign Overflow              = overflow_q;
    assign PixelCount            = count_q;
    assign DataToRAM             = pixel_q;
    assign AddressInDecompressed = base_q + count_q;

endmodule

// File: tb/tb_rle_image_decompressor.sv
// Directed bench for rle_image_decompressor with an 8-pixel image: table of
// jobs plus hand-written reset and abort sequences.
module tb_rle_image_decompressor;

    localparam int AW = 16;
    localparam int PW = 8;
    localparam int RW = 8;
    localparam int IMG = 8;

    logic          clk;
    logic          rst;
    logic          Start;
    logic [AW-1:0] BaseAddress;
    logic [15:0]   InData;
    logic          InValid;
    logic          InReady;
    logic [AW-1:0] AddressInDecompressed;
    logic [PW-1:0] DataToRAM;
    logic          WriteEnable;
    logic          Load;
    logic          Done;
    logic          Overflow;
    logic [AW-1:0] PixelCount;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int doneCount = 0;
    int doneCycle = 0;
    logic [AW-1:0] wrAddr[$];
    logic [PW-1:0] wrData[$];
    int            wrCycle[$];

    typedef struct {
        logic [15:0] base;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          nWords;
        bit          stall;
        bit          holdStart;
        int          expWrites;
        logic [15:0] expCount;
        bit          expOvf;
        int          expConsumed;
        logic [15:0] expLastAddr;
        logic [7:0]  expLastData;
        int          expDoneGap;
    } vec_t;

    vec_t vecs[6];

    rle_image_decompressor #(
        .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .RUN_WIDTH(RW), .IMAGE_SIZE(IMG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Start(Start),
        .BaseAddress(BaseAddress),
        .InData(InData),
        .InValid(InValid),
        .InReady(InReady),
        .AddressInDecompressed(AddressInDecompressed),
        .DataToRAM(DataToRAM),
        .WriteEnable(WriteEnable),
        .Load(Load),
        .Done(Done),
        .Overflow(Overflow),
        .PixelCount(PixelCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Capture every RAM write and Done pulse mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (WriteEnable) begin
                wrAddr.push_back(AddressInDecompressed);
                wrData.push_back(DataToRAM);
                wrCycle.push_back(cycle);
            end
            if (Done) begin
                doneCount = doneCount + 1;
                doneCycle = cycle;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Runs one image job from the table and checks writes, counters and handshake.
    task automatic applyStimulus(input vec_t v, input int id);
        logic [15:0] words[3];
        logic [15:0] expA[$];
        logic [7:0]  expD[$];
        int  wi;
        int  n;
        bit  valid;
        bit  acc;
        bit  seenDone;
        bit  seqOk;
        int  run;
        words = '{v.w0, v.w1, v.w2};
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        doneCount = 0;

        n = 0;
        for (int k = 0; k < v.nWords; k++) begin
            run = int'(words[k][15:8]);
            if (run == 0) break;
            for (int r = 0; r < run && n < IMG; r++) begin
                expA.push_back(v.base + 16'(n));
                expD.push_back(words[k][7:0]);
                n++;
            end
            if (n >= IMG) break;
        end

        BaseAddress = v.base;
        InData = words[0];
        InValid = 1'b1;
        Start = 1'b1;
        @(posedge clk); #1;
        if (!v.holdStart) Start = 1'b0;
        checkOutput($sformatf("job%0d ready after start", id), InReady, 1);
        checkOutput($sformatf("job%0d overflow cleared", id), Overflow, 0);

        wi = 0;
        seenDone = 0;
        for (int c = 0; c < 200 && !seenDone; c++) begin
            valid = (wi < v.nWords) && (!v.stall || (c % 2 == 1));
            InValid = valid;
            InData = (wi < 3) ? words[wi] : 16'h0000;
            acc = valid && InReady;
            @(posedge clk); #1;
            if (acc) wi++;
            if (Done) seenDone = 1;
        end
        InValid = 1'b0;
        checkOutput($sformatf("job%0d done seen", id), seenDone, 1);
        checkOutput($sformatf("job%0d load in finish", id), Load, 1);
        @(posedge clk); #1;
        Start = 1'b0;
        checkOutput($sformatf("job%0d idle after finish", id), Load, 0);
        checkOutput($sformatf("job%0d ready idle", id), InReady, 0);
        @(posedge clk); #1;
        checkOutput($sformatf("job%0d start ignored", id), Load, 0);

        checkOutput($sformatf("job%0d write count", id), wrAddr.size(), v.expWrites);
        checkOutput($sformatf("job%0d pixel count", id), PixelCount, v.expCount);
        checkOutput($sformatf("job%0d overflow", id), Overflow, v.expOvf);
        checkOutput($sformatf("job%0d words consumed", id), wi, v.expConsumed);
        checkOutput($sformatf("job%0d done pulses", id), doneCount, 1);
        if (wrAddr.size() > 0) begin
            checkOutput($sformatf("job%0d last addr", id), wrAddr[wrAddr.size()-1], v.expLastAddr);
            checkOutput($sformatf("job%0d last data", id), wrData[wrData.size()-1], v.expLastData);
            checkOutput($sformatf("job%0d done timing", id), doneCycle - wrCycle[wrCycle.size()-1], v.expDoneGap);
        end else begin
            checkOutput($sformatf("job%0d any write", id), 0, 1);
        end

        seqOk = (wrAddr.size() == expA.size());
        for (int k = 0; k < expA.size() && seqOk; k++) begin
            if (wrAddr[k] !== expA[k] || wrData[k] !== expD[k]) seqOk = 0;
        end
        checkOutput($sformatf("job%0d write sequence", id), seqOk, 1);

        // Without stalls the only gap inside the basic image is the single FETCH cycle.
        if (id == 0 && wrCycle.size() == 8) begin
            checkOutput("job0 run no bubbles", wrCycle[2] - wrCycle[0], 2);
            checkOutput("job0 fetch gap", wrCycle[3] - wrCycle[2], 2);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int weSeen;
        vecs[0] = '{16'h0100, 16'h03AA, 16'h0555, 16'h0000, 2, 1'b0, 1'b0, 8, 16'd8, 1'b0, 2, 16'h0107, 8'h55, 1};
        vecs[1] = '{16'h0200, 16'h0211, 16'h0000, 16'h0399, 3, 1'b0, 1'b0, 2, 16'd2, 1'b0, 2, 16'h0201, 8'h11, 2};
        vecs[2] = '{16'h0300, 16'h0A7F, 16'h0122, 16'h0000, 2, 1'b0, 1'b0, 8, 16'd8, 1'b1, 1, 16'h0307, 8'h7F, 1};
        vecs[3] = '{16'h0100, 16'h03AA, 16'h0555, 16'h0000, 2, 1'b1, 1'b1, 8, 16'd8, 1'b0, 2, 16'h0107, 8'h55, 1};
        vecs[4] = '{16'hFFFE, 16'h0433, 16'h0000, 16'h0000, 2, 1'b0, 1'b0, 4, 16'd4, 1'b0, 2, 16'h0001, 8'h33, 2};
        vecs[5] = '{16'h0010, 16'h08C3, 16'h0155, 16'h0000, 2, 1'b0, 1'b0, 8, 16'd8, 1'b0, 1, 16'h0017, 8'hC3, 1};

        rst = 1'b1;
        Start = 1'b0;
        BaseAddress = 16'h0000;
        InData = 16'h0000;
        InValid = 1'b0;
        #1;
        checkOutput("reset load", Load, 0);
        checkOutput("reset ready", InReady, 0);
        checkOutput("reset address", AddressInDecompressed, 0);
        checkOutput("reset data", DataToRAM, 0);
        checkOutput("reset we", WriteEnable, 0);
        checkOutput("reset done", Done, 0);
        checkOutput("reset overflow", Overflow, 0);
        checkOutput("reset count", PixelCount, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        InValid = 1'b1;
        InData = 16'h0312;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle load", Load, 0);
        checkOutput("idle ready", InReady, 0);
        checkOutput("idle writes", wrAddr.size(), 0);
        InValid = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

        // Abort: reset in the middle of a wrapping run.
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        doneCount = 0;
        BaseAddress = 16'hFFFE;
        InData = 16'h0433;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        InValid = 1'b1;
        weSeen = 0;
        for (int c = 0; c < 50 && weSeen < 2; c++) begin
            @(posedge clk); #1;
            if (WriteEnable) begin
                weSeen++;
                InValid = 1'b0;
            end
        end
        checkOutput("abort second write addr", AddressInDecompressed, 16'hFFFF);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort load", Load, 0);
        checkOutput("abort we", WriteEnable, 0);
        checkOutput("abort ready", InReady, 0);
        checkOutput("abort done", Done, 0);
        checkOutput("abort count", PixelCount, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort writes before reset", wrAddr.size(), 1);
        checkOutput("abort no done", doneCount, 0);
        checkOutput("abort stays idle", Load, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
